// File: rtl/xnor_pkg.sv
// Shared definitions for the XNOR match unit: operation
// encodings and the distance-width helper.
package xnor_pkg;

    localparam logic [1:0] MODE_XNOR = 2'b00;
    localparam logic [1:0] MODE_XOR  = 2'b01;
    localparam logic [1:0] MODE_NAND = 2'b10;
    localparam logic [1:0] MODE_NOR  = 2'b11;

    // Bits needed to hold a count of 0..width.
    function automatic int calc_dw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/xnor_match_unit_if.sv
// Operand/result bundle of the XNOR match unit.
// master drives operands, slave returns results.
interface xnor_match_unit_if
    import xnor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    localparam int DW = calc_dw(WIDTH);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             cnt_clr;
    logic             out_valid;
    logic [WIDTH-1:0] out_bits;
    logic             out_eq;
    logic [DW-1:0]    out_dist;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output in_valid, a, b, mode, cnt_clr,
        input  out_valid, out_bits, out_eq,
        input  out_dist, match_cnt, cnt_sat
    );

    modport slave (
        input  in_valid, a, b, mode, cnt_clr,
        output out_valid, out_bits, out_eq,
        output out_dist, match_cnt, cnt_sat
    );

endinterface

// File: rtl/popcount.sv
// Combinational population count built as a recursive
// binary adder tree.
module popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]             i_bits,
    output logic [$clog2(WIDTH+1)-1:0]   o_count
);
    localparam int DW = $clog2(WIDTH + 1);

    if (WIDTH == 1) begin : g_leaf
        assign o_count = i_bits;
    end else begin : g_tree
        localparam int LW  = WIDTH / 2;
        localparam int HW  = WIDTH - LW;
        localparam int LDW = $clog2(LW + 1);
        localparam int HDW = $clog2(HW + 1);

        logic [LDW-1:0] w_lo;
        logic [HDW-1:0] w_hi;

        popcount #(.WIDTH(LW)) u_lo (
            .i_bits  (i_bits[LW-1:0]),
            .o_count (w_lo)
        );

        popcount #(.WIDTH(HW)) u_hi (
            .i_bits  (i_bits[WIDTH-1:LW]),
            .o_count (w_hi)
        );

        assign o_count = DW'(w_lo) + DW'(w_hi);
    end

endmodule

// File: rtl/xnor_match_unit.sv
// Two-stage bitwise compare unit: selectable logic op,
// equality, Hamming distance and saturating match count.
module xnor_match_unit
    import xnor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst,
    xnor_match_unit_if.slave bus
);
    localparam int DW = calc_dw(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_diff;
    logic [WIDTH-1:0] r_s1_res;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_bits;
    logic             r_out_eq;
    logic [DW-1:0]    r_out_dist;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_sat;
    logic [WIDTH-1:0] w_res;
    logic [DW-1:0]    w_dist;

    // Select the bitwise operation for the incoming beat.
    always_comb begin
        w_res = '0;
        unique case (bus.mode)
            MODE_XNOR: w_res = ~(bus.a ^ bus.b);
            MODE_XOR:  w_res = bus.a ^ bus.b;
            MODE_NAND: w_res = ~(bus.a & bus.b);
            MODE_NOR:  w_res = ~(bus.a | bus.b);
        endcase
    end

    // Stage 1: capture diff and result; hold data on bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_diff  <= '0;
            r_s1_res   <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_diff <= bus.a ^ bus.b;
                r_s1_res  <= w_res;
            end
        end
    end

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .i_bits  (r_s1_diff),
        .o_count (w_dist)
    );

    // Stage 2: register outputs; hold data on bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
            r_out_eq    <= 1'b0;
            r_out_dist  <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_bits <= r_s1_res;
                r_out_eq   <= (r_s1_diff == '0);
                r_out_dist <= w_dist;
            end
        end
    end

    // Saturating match counter; clear beats a coincident match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt <= '0;
            r_sat       <= 1'b0;
        end else if (bus.cnt_clr) begin
            r_match_cnt <= '0;
            r_sat       <= 1'b0;
        end else if (r_out_valid && r_out_eq &&
                     r_match_cnt != CNT_MAX) begin
            r_match_cnt <= r_match_cnt + CNT_W'(1);
            if (r_match_cnt == CNT_MAX - CNT_W'(1)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_bits  = r_out_bits;
    assign bus.out_eq    = r_out_eq;
    assign bus.out_dist  = r_out_dist;
    assign bus.match_cnt = r_match_cnt;
    assign bus.cnt_sat   = r_sat;

endmodule

// File: doc/xnor_match_unit.md
Name: xnor_match_unit

Overview:
Parametrised, pipelined successor to the single-bit XNOR gate. It performs a WIDTH-bit bitwise logic operation selectable per transaction (XNOR/XOR/NAND/NOR) and computes equality and Hamming distance of the operands. It also keeps a saturating count of equal-operand events. It serves as the comparison and match-counting element in pattern-detect and self-check datapaths.

Parameters:
WIDTH, 8, operand width in bits (>= 1)
CNT_W, 8, width of the match counter (>= 1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand strobe; one transaction per cycle when high
a  input  WIDTH  operand A
b  input  WIDTH  operand B
mode  input  2  operation select: 00 XNOR, 01 XOR, 10 NAND, 11 NOR
cnt_clr  input  1  synchronous clear of match_cnt and cnt_sat
out_valid  output  1  result strobe, in_valid delayed 2 cycles
out_bits  output  WIDTH  bitwise result of the selected mode
out_eq  output  1  1 when a == b
out_dist  output  DW  Hamming distance popcount(a ^ b); DW = $clog2(WIDTH+1)
match_cnt  output  CNT_W  count of result beats with out_eq = 1
cnt_sat  output  1  sticky flag, set when match_cnt is at its maximum

Behaviour:
- Reset (async assert, applied immediately): all pipeline registers and outputs go to 0, including out_valid, out_bits, out_eq, out_dist, match_cnt and cnt_sat. On deassertion, operation resumes on the next rising edge.
- No backpressure. Every cycle with in_valid = 1 is accepted.
- Latency is exactly 2 cycles. Full throughput of one result per cycle.
- Stage 1 (on in_valid): register diff = a ^ b, the mode-selected bitwise result, and the valid bit.
  - 00: ~(a ^ b)
  - 01: a ^ b
  - 10: ~(a & b)
  - 11: ~(a | b)
  - mode is sampled with its operands, so a mode change between beats affects only subsequent beats.
- Stage 2: register the following from the stage-1 values.
  - out_bits = stage-1 result.
  - out_eq = (diff == 0).
  - out_dist = popcount(diff), range 0..WIDTH, zero-extended to DW.
  - out_valid = stage-1 valid.
- Bubbles: when a stage's valid is 0, its data registers hold their previous value. Only out_valid drops. Data outputs are meaningful only while out_valid = 1.
- Counter update, on each rising edge, in priority order:
  1. cnt_clr = 1: match_cnt <= 0 and cnt_sat <= 0. A simultaneous match beat is discarded (clear wins).
  2. Else, if out_valid and out_eq and match_cnt < 2^CNT_W - 1: match_cnt increments by 1.
  3. Else, if at the maximum: match_cnt holds (saturates, never wraps).
- cnt_sat is set on the same edge at which match_cnt becomes 2^CNT_W - 1. It stays set until cnt_clr or rst.
- The counter acts on the stage-2 (output) beat, so match_cnt reflects a beat one cycle after out_valid.
- Reset mid-stream: in-flight beats are dropped. No out_valid pulse appears after reset for beats accepted before reset.

Decomposition:
- Shared package xnor_pkg holds:
  - mode encodings MODE_XNOR=2'b00, MODE_XOR=2'b01, MODE_NAND=2'b10, MODE_NOR=2'b11.
  - a function for DW (clog2 of WIDTH+1).
- One sub-module, popcount (parameter WIDTH, combinational adder tree), instantiated in stage 2 for out_dist.

Test Plan:
- WIDTH=8, reset then idle: all outputs 0. Then a=8'hA5, b=8'hA5, mode=00, one beat -> 2 cycles later out_valid=1, out_bits=8'hFF, out_eq=1, out_dist=0; next cycle match_cnt=1.
- Mode sweep with a=8'hF0, b=8'h3C, one beat per mode back-to-back -> consecutive out_bits:
  - 00: 8'h33
  - 01: 8'hCC
  - 10: 8'hCF
  - 11: 8'h03
  - out_dist=4 and out_eq=0 for all four beats; match_cnt unchanged.
- Bubble pattern in_valid=1,0,1 with a=8'h00, b=8'hFF then a=8'h01, b=8'h01 -> out_valid=1,0,1.
  - First beat: out_dist=8.
  - Third beat: out_eq=1.
  - Data held during the bubble.
- CNT_W=3, 9 consecutive equal beats -> match_cnt reaches 7 after 7 beats, cnt_sat=1 on the same edge, then both hold at 7/1. cnt_clr -> 0/0.
- cnt_clr asserted on the same cycle as an equal result beat with match_cnt=2 -> match_cnt=0 (increment discarded).
- rst pulsed asynchronously mid-cycle, 1 cycle after accepting a beat -> outputs 0 immediately; no out_valid for that beat after release; match_cnt=0.
